// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: shared FSM encoding and default widths for cordic_rr_sched.
// No ports; imported by the scheduler top.
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [15:0] PI_Q = 16'd25735;

    localparam int WIDTH_WIRE = 18;
    localparam int WIDTH      = 16;

endpackage

// File: rtl/cordic_rr_sched_arbiter.sv
// rr_arbiter: combinational round-robin pick, first valid at or after ptr.
// Ports: req_valid in, ptr in; grant (one-hot), idx, any out.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Outer loop walks priority offsets from ptr; inner loop keeps
    // every select constant so no variable index is needed.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any && req_valid[j] &&
                    (((int'(ptr) + off) % NUM_REQ) == j)) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    idx      = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/cordic_rr_sched.sv
// cordic_rr_sched: round-robin share of one iterative CORDIC engine.
// Ports: req_* operand channel in, cor_* engine side, rsp_* tagged result
// channel out, busy status; err (timeout pulse) only with
// CORDIC_SCHED_TIMEOUT_EN defined, which also adds the TIMEOUT parameter.
module cordic_rr_sched #(
    parameter int NUM_REQ    = 2,
    parameter int WIDTH_WIRE = cordic_sched_pkg::WIDTH_WIRE,
    parameter int WIDTH      = cordic_sched_pkg::WIDTH,
`ifdef CORDIC_SCHED_TIMEOUT_EN
    parameter int TIMEOUT    = 40,
`endif
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WIDTH_WIRE-1:0] req_x,
    input  logic [NUM_REQ*WIDTH_WIRE-1:0] req_y,
    output logic                          cor_start,
    output logic [WIDTH_WIRE-1:0]         cor_x,
    output logic [WIDTH_WIRE-1:0]         cor_y,
    input  logic                          cor_ready,
    input  logic [WIDTH_WIRE-1:0]         cor_x_res,
    input  logic [WIDTH_WIRE-1:0]         cor_y_res,
    input  logic [WIDTH-1:0]              cor_z_res,
`ifdef CORDIC_SCHED_TIMEOUT_EN
    output logic                          err,
`endif
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [WIDTH_WIRE-1:0]         rsp_x,
    output logic [WIDTH_WIRE-1:0]         rsp_y,
    output logic [WIDTH-1:0]              rsp_z,
    output logic                          busy
);

    import cordic_sched_pkg::*;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       gid_q, gid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH_WIRE-1:0] cor_x_q, cor_x_d;
    logic [WIDTH_WIRE-1:0] cor_y_q, cor_y_d;
    logic [WIDTH_WIRE-1:0] rsp_x_q, rsp_x_d;
    logic [WIDTH_WIRE-1:0] rsp_y_q, rsp_y_d;
    logic [WIDTH-1:0]      rsp_z_q, rsp_z_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .idx       (gnt_idx),
        .any       (gnt_any)
    );

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q holds the number of RUN cycles already spent, so the
    // TIMEOUT-th RUN cycle is the last one the engine gets.
    assign timeout_hit = (state_q == RUN) && !cor_ready &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        err_d = timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gid_q    <= '0;
            rsp_id_q <= '0;
            cor_x_q  <= '0;
            cor_y_q  <= '0;
            rsp_x_q  <= '0;
            rsp_y_q  <= '0;
            rsp_z_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            rsp_id_q <= rsp_id_d;
            cor_x_q  <= cor_x_d;
            cor_y_q  <= cor_y_d;
            rsp_x_q  <= rsp_x_d;
            rsp_y_q  <= rsp_y_d;
            rsp_z_q  <= rsp_z_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = RUN;
            RUN:     if (cor_ready || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        rsp_id_d = rsp_id_q;
        cor_x_d  = cor_x_q;
        cor_y_d  = cor_y_q;
        rsp_x_d  = rsp_x_q;
        rsp_y_d  = rsp_y_q;
        rsp_z_d  = rsp_z_q;

        if (state_q == IDLE && gnt_any) begin
            gid_d = gnt_idx;
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ?
                    '0 : gnt_idx + ID_W'(1);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant[j]) begin
                    cor_x_d = req_x[j*WIDTH_WIRE +: WIDTH_WIRE];
                    cor_y_d = req_y[j*WIDTH_WIRE +: WIDTH_WIRE];
                end
            end
        end

        if (state_q == RUN) begin
            if (cor_ready) begin
                rsp_id_d = gid_q;
                rsp_x_d  = cor_x_res;
                rsp_y_d  = cor_y_res;
                rsp_z_d  = cor_z_res;
            end else if (timeout_hit) begin
                rsp_id_d = gid_q;
                rsp_x_d  = '0;
                rsp_y_d  = '0;
                rsp_z_d  = '0;
            end
        end
    end

    // Outputs; req_ready is masked by reset so nothing is granted while
    // the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && rst_n) begin
            req_ready = grant;
        end
        cor_start = (state_q == RUN);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        cor_x     = cor_x_q;
        cor_y     = cor_y_q;
        rsp_id    = rsp_id_q;
        rsp_x     = rsp_x_q;
        rsp_y     = rsp_y_q;
        rsp_z     = rsp_z_q;
    end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// tb_cordic_rr_sched: scoreboard bench for cordic_rr_sched with an
// engine model; timeout scenario runs with CORDIC_SCHED_TIMEOUT_EN.
module tb_cordic_rr_sched;

    localparam int NUM_REQ = 2;
    localparam int WW      = 18;
    localparam int WZ      = 16;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [WW-1:0] x;
        logic [WW-1:0] y;
    } op_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [WW-1:0]   x;
        logic [WW-1:0]   y;
        logic [WZ-1:0]   z;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*WW-1:0] req_x;
    logic [NUM_REQ*WW-1:0] req_y;
    logic                  cor_start;
    logic [WW-1:0]         cor_x, cor_y;
    logic                  cor_ready;
    logic [WW-1:0]         cor_x_res, cor_y_res;
    logic [WZ-1:0]         cor_z_res;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WW-1:0]         rsp_x, rsp_y;
    logic [WZ-1:0]         rsp_z;
    logic                  busy;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    logic                  err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_rr_sched #(
        .NUM_REQ    (NUM_REQ),
        .WIDTH_WIRE (WW),
        .WIDTH      (WZ),
        .ID_W       (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .cor_start (cor_start),
        .cor_x     (cor_x),
        .cor_y     (cor_y),
        .cor_ready (cor_ready),
        .cor_x_res (cor_x_res),
        .cor_y_res (cor_y_res),
        .cor_z_res (cor_z_res),
`ifdef CORDIC_SCHED_TIMEOUT_EN
        .err       (err),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z),
        .busy      (busy)
    );

    // Engine model: fixed transform of the operands, done pulse on the
    // eng_lat-th cycle that cor_start is high.
    function automatic logic [WW-1:0] eng_x(input logic [WW-1:0] x);
        return x + 18'd3;
    endfunction
    function automatic logic [WW-1:0] eng_y(input logic [WW-1:0] y);
        return y - 18'd5;
    endfunction
    function automatic logic [WZ-1:0] eng_z(input logic [WW-1:0] x,
                                             input logic [WW-1:0] y);
        return x[WZ-1:0] ^ y[WZ-1:0] ^ 16'h1234;
    endfunction
    function automatic rsp_t exp_rsp(input logic [ID_W-1:0] id,
                                     input logic [WW-1:0] x,
                                     input logic [WW-1:0] y);
        rsp_t r;
        r.id = id;
        r.x  = eng_x(x);
        r.y  = eng_y(y);
        r.z  = eng_z(x, y);
        return r;
    endfunction

    assign cor_x_res = eng_x(cor_x);
    assign cor_y_res = eng_y(cor_y);
    assign cor_z_res = eng_z(cor_x, cor_y);

    logic eng_rdy  = 1'b0;
    logic spur_rdy = 1'b0;
    bit   eng_en   = 1'b1;
    int   eng_lat  = 16;
    int   run_cnt  = 0;
    assign cor_ready = eng_rdy | spur_rdy;

    always @(negedge clk) begin
        if (cor_start) run_cnt++;
        else run_cnt = 0;
        eng_rdy = eng_en && cor_start && (run_cnt == eng_lat);
    end

    // Requesters: present the head of their operand queue, pop on grant.
    op_t  op_q0[$];
    op_t  op_q1[$];
    rsp_t sb[$];
    int   grant_log[$];
    bit   took0, took1;

    always @(posedge clk) begin
        #1;
        if (took0) begin
            took0 = 1'b0;
            if (op_q0.size() != 0) op_q0.delete(0);
        end
        if (took1) begin
            took1 = 1'b0;
            if (op_q1.size() != 0) op_q1.delete(0);
        end
        req_valid[0] = (op_q0.size() != 0);
        req_valid[1] = (op_q1.size() != 0);
        if (op_q0.size() != 0) begin
            req_x[0 +: WW] = op_q0[0].x;
            req_y[0 +: WW] = op_q0[0].y;
        end
        if (op_q1.size() != 0) begin
            req_x[WW +: WW] = op_q1[0].x;
            req_y[WW +: WW] = op_q1[0].y;
        end
    end

    // Monitor and scoreboard
    int cyc = 0, cs_cnt = 0, first_cs_cyc = -1, last_cs_cyc = -1;
    int first_rv_cyc = -1, grant_cyc = -1;
    int rr_cnt0 = 0, rr_cnt1 = 0, rr_cycles = 0, rr_double = 0;
    int err_cnt = 0, err_cyc = -1;
    bit prev_cs = 0, prev_rv = 0, prev_rr = 0;

    always @(negedge clk) begin
        rsp_t e;
        cyc++;
        if (req_ready[0]) begin
            grant_log.push_back(0);
            rr_cnt0++;
            took0 = 1'b1;
        end
        if (req_ready[1]) begin
            grant_log.push_back(1);
            rr_cnt1++;
            took1 = 1'b1;
        end
        if (|req_ready) begin
            rr_cycles++;
            grant_cyc = cyc;
            if (prev_rr) rr_double++;
        end
        prev_rr = |req_ready;
        if (cor_start) begin
            if (!prev_cs) first_cs_cyc = cyc;
            cs_cnt++;
            last_cs_cyc = cyc;
        end
        prev_cs = cor_start;
        if (rsp_valid && !prev_rv) first_rv_cyc = cyc;
        prev_rv = rsp_valid;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
`endif
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d x=%0d y=%0d z=%0d, want none",
                         rsp_id, rsp_x, rsp_y, rsp_z);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_x, rsp_y, rsp_z} !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d x=%0d y=%0d z=%0d, want id=%0d x=%0d y=%0d z=%0d",
                             rsp_id, rsp_x, rsp_y, rsp_z, e.id, e.x, e.y, e.z);
                end
            end
        end
    end

    task automatic clear_stats();
        cs_cnt = 0;
        first_cs_cyc = -1;
        last_cs_cyc = -1;
        first_rv_cyc = -1;
        grant_cyc = -1;
        rr_cnt0 = 0;
        rr_cnt1 = 0;
        rr_cycles = 0;
        rr_double = 0;
        err_cnt = 0;
        err_cyc = -1;
        grant_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        op_q0.delete();
        op_q1.delete();
        sb.delete();
        took0 = 1'b0;
        took1 = 1'b0;
        rsp_ready = 1'b1;
        spur_rdy = 1'b0;
        eng_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_stats();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && op_q0.size() == 0 && op_q1.size() == 0 &&
                !busy && !took0 && !took1 && req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cor_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rv(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        #2 rst_n = 1'b0;
        op_q0.push_back('{x: 18'd11, y: 18'd12});
        op_q1.push_back('{x: 18'd21, y: 18'd22});
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, cor_start, rsp_valid, busy} !== 5'b0 || req_valid !== 2'b11) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b start=%b rv=%b busy=%b valid=%b, want 0,0,0,0 with valid=11",
                     req_ready, cor_start, rsp_valid, busy, req_valid);
        end
        checks++;
        if ({cor_x, cor_y} !== '0) begin
            errors++;
            $display("FAIL reset_cor: got x=%0d y=%0d, want 0", cor_x, cor_y);
        end
        checks++;
        if ({rsp_id, rsp_x, rsp_y, rsp_z} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got id=%0d x=%0d y=%0d z=%0d, want 0",
                     rsp_id, rsp_x, rsp_y, rsp_z);
        end
        op_q0.delete();
        op_q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, req_ready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b rv=%b rdy=%b, want 0",
                     busy, rsp_valid, req_ready);
        end
        clear_stats();
    endtask

    task automatic test_single();
        bit ok;
        clear_stats();
        op_q0.push_back('{x: 18'd1000, y: 18'd0});
        sb.push_back(exp_rsp(2'd0, 18'd1000, 18'd0));
        wait_cs(40, ok);
        checks++;
        if (!ok || cor_x !== 18'd1000 || cor_y !== 18'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_run: got start=%b x=%0d y=%0d busy=%b, want 1,1000,0,1",
                     ok, cor_x, cor_y, busy);
        end
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done: got timeout, want completion");
        end
        checks++;
        if (rr_cnt0 != 1 || rr_cnt1 != 0) begin
            errors++;
            $display("FAIL single_ready: got pulses %0d/%0d, want 1/0", rr_cnt0, rr_cnt1);
        end
        checks++;
        if (first_cs_cyc != grant_cyc + 1) begin
            errors++;
            $display("FAIL single_start_lat: got cycle %0d, want %0d", first_cs_cyc, grant_cyc + 1);
        end
        checks++;
        if (cs_cnt != 16) begin
            errors++;
            $display("FAIL single_start_len: got %0d, want 16", cs_cnt);
        end
        checks++;
        if (first_rv_cyc != last_cs_cyc + 1) begin
            errors++;
            $display("FAIL single_rsp_lat: got cycle %0d, want %0d", first_rv_cyc, last_cs_cyc + 1);
        end
    endtask

    task automatic test_contention();
        bit ok;
        logic [15:0] order;
        do_reset();
        op_q0.push_back('{x: 18'd100, y: 18'h3FF00});
        op_q0.push_back('{x: 18'd101, y: 18'h3FF01});
        op_q1.push_back('{x: 18'd200, y: 18'd7});
        op_q1.push_back('{x: 18'h20000, y: 18'h1FFFF});
        sb.push_back(exp_rsp(2'd0, 18'd100, 18'h3FF00));
        sb.push_back(exp_rsp(2'd1, 18'd200, 18'd7));
        sb.push_back(exp_rsp(2'd0, 18'd101, 18'h3FF01));
        sb.push_back(exp_rsp(2'd1, 18'h20000, 18'h1FFFF));
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL contention_done: got timeout, want completion");
        end
        order = '0;
        foreach (grant_log[i]) order = {order[11:0], 4'(grant_log[i])};
        checks++;
        if (grant_log.size() != 4 || order !== 16'h0101) begin
            errors++;
            $display("FAIL contention_order: got %0d grants %h, want 4 grants 0101",
                     grant_log.size(), order);
        end
        checks++;
        if (rr_cycles != 4 || rr_double != 0) begin
            errors++;
            $display("FAIL contention_pulse: got %0d ready cycles %0d back-to-back, want 4 and 0",
                     rr_cycles, rr_double);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [ID_W-1:0] sid;
        logic [WW-1:0]   sx, sy;
        logic [WZ-1:0]   sz;
        rsp_ready = 1'b0;
        op_q0.push_back('{x: 18'd555, y: 18'd444});
        sb.push_back(exp_rsp(2'd0, 18'd555, 18'd444));
        wait_rv(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_rsp_valid: got no rsp_valid, want 1");
        end
        op_q1.push_back('{x: 18'd777, y: 18'd888});
        sb.push_back(exp_rsp(2'd1, 18'd777, 18'd888));
        grant_log.delete();
        sid = rsp_id;
        sx = rsp_x;
        sy = rsp_y;
        sz = rsp_z;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, cor_start, req_ready} !==
                {1'b1, sid, sx, sy, sz, 1'b0, 2'b00} || req_valid[1] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cyc %0d got rv=%b x=%0d start=%b rdy=%b, want 1,%0d,0,00",
                         i, rsp_valid, rsp_x, cor_start, req_ready, sx);
            end
        end
        rsp_ready = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok || grant_log.size() != 1 || grant_log[0] != 1) begin
            errors++;
            $display("FAIL bp_release: got ok=%b grants=%0d, want ok=1 single grant to 1",
                     ok, grant_log.size());
        end
    endtask

    task automatic test_spurious();
        bit ok;
        logic [ID_W-1:0] sid;
        logic [WW-1:0]   sx, sy;
        logic [WZ-1:0]   sz;
        sid = rsp_id;
        sx = rsp_x;
        sy = rsp_y;
        sz = rsp_z;
        spur_rdy = 1'b1;
        @(negedge clk);
        spur_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, cor_start, rsp_valid} !== 3'b0 ||
            {rsp_id, rsp_x, rsp_y, rsp_z} !== {sid, sx, sy, sz}) begin
            errors++;
            $display("FAIL spur_idle: got busy=%b rv=%b x=%0d, want 0,0,%0d",
                     busy, rsp_valid, rsp_x, sx);
        end
        rsp_ready = 1'b0;
        op_q0.push_back('{x: 18'd4242, y: 18'h2ABCD});
        sb.push_back(exp_rsp(2'd0, 18'd4242, 18'h2ABCD));
        wait_rv(60, ok);
        sid = rsp_id;
        sx = rsp_x;
        sy = rsp_y;
        sz = rsp_z;
        spur_rdy = 1'b1;
        @(negedge clk);
        spur_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || {rsp_valid, busy, cor_start} !== 3'b110 ||
            {rsp_id, rsp_x, rsp_y, rsp_z} !== {sid, sx, sy, sz}) begin
            errors++;
            $display("FAIL spur_resp: got rv=%b busy=%b start=%b x=%0d, want 1,1,0,%0d",
                     rsp_valid, busy, cor_start, rsp_x, sx);
        end
        rsp_ready = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL spur_done: got timeout, want completion");
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] order;
        do_reset();
        op_q0.push_back('{x: 18'd9999, y: 18'd1});
        wait_cs(40, ok);
        repeat (6) @(negedge clk);
        checks++;
        if (!ok || cor_start !== 1'b1) begin
            errors++;
            $display("FAIL rmid_run: got start=%b, want 1 at run cycle 7", cor_start);
        end
        rst_n = 1'b0;
        op_q0.push_back('{x: 18'd31, y: 18'd32});
        op_q1.push_back('{x: 18'd41, y: 18'd42});
        sb.push_back(exp_rsp(2'd0, 18'd31, 18'd32));
        sb.push_back(exp_rsp(2'd1, 18'd41, 18'd42));
        #1;
        checks++;
        if ({req_ready, cor_start, rsp_valid, busy, cor_x, cor_y,
             rsp_id, rsp_x, rsp_y, rsp_z} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: got start=%b busy=%b cor_x=%0d rsp_x=%0d, want all 0",
                     cor_start, busy, cor_x, rsp_x);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || req_valid !== 2'b11) begin
            errors++;
            $display("FAIL rmid_hold: got rdy=%b valid=%b, want 00 with valid 11",
                     req_ready, req_valid);
        end
        grant_log.delete();
        rst_n = 1'b1;
        wait_done(200, ok);
        order = '0;
        foreach (grant_log[i]) order = {order[3:0], 4'(grant_log[i])};
        checks++;
        if (!ok || grant_log.size() != 2 || order !== 8'h01) begin
            errors++;
            $display("FAIL rmid_order: got ok=%b %0d grants %h, want 2 grants 01",
                     ok, grant_log.size(), order);
        end
    endtask

`ifdef CORDIC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        eng_en = 1'b0;
        op_q0.push_back('{x: 18'd123, y: 18'd456});
        sb.push_back('{id: 2'd0, x: 18'd0, y: 18'd0, z: 16'd0});
        wait_done(200, ok);
        checks++;
        if (!ok || cs_cnt != 40) begin
            errors++;
            $display("FAIL timeout_len: got ok=%b start cycles %0d, want 40", ok, cs_cnt);
        end
        checks++;
        if (err_cnt != 1 || err_cyc != first_rv_cyc) begin
            errors++;
            $display("FAIL timeout_err: got %0d pulses at %0d, want 1 at %0d",
                     err_cnt, err_cyc, first_rv_cyc);
        end
        eng_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_spurious();
        test_reset_mid();
`ifdef CORDIC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
